// File: rtl/mdu_pkg.sv
// Shared types and flag layout for the multi-cycle multiply/divide unit.
// The flag bit positions match what the condition logic consumes.
package mdu_pkg;

  typedef enum logic {
    OP_MUL,
    OP_DIVU
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_O = 0;

endpackage

// File: rtl/mdu_flaggen.sv
// Completion flags {CF,ZF,SF,OF} derived from the final result.
// Purely combinational; evaluated on the values about to be registered.
module mdu_flaggen
  import mdu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] res_lo,
  input  logic [WIDTH-1:0] res_hi,
  input  logic             div0,
  output logic [3:0]       flags
);

  always_comb begin
    flags = '0;
    flags[FLAG_Z] = (res_lo == '0);
    flags[FLAG_S] = res_lo[WIDTH-1];
    unique case (op)
      OP_MUL: begin
        flags[FLAG_C] = (res_hi != '0);
        flags[FLAG_O] = (res_hi != '0);
      end
      OP_DIVU: begin
        flags[FLAG_C] = div0;
        flags[FLAG_O] = 1'b0;
      end
      default: flags = '0;
    endcase
  end

endmodule

// File: rtl/seq_muldiv.sv
// Sequential 16-bit unsigned MUL/DIVU with start/busy/done handshake.
// One shift-add or restoring-divide step per clock over a shared accumulator.
module seq_muldiv
  import mdu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             flag_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [3:0]       flags,
  output logic             flag_w
);

  state_t             state, state_nx;
  op_t                op_q;
  logic               fe_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc, acc_nx;
  logic [CNTW-1:0]    cnt;

  logic               accept, div0_go, last, finish;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] mul_nx, div_nx;

  op_t                fin_op;
  logic [WIDTH-1:0]   fin_lo, fin_hi;
  logic               fin_div0;
  logic [3:0]         fin_flags;

  assign accept  = start && (state == S_IDLE || state == S_DONE);
  assign div0_go = accept && op && (b == '0);
  assign last    = (state == S_RUN) && (cnt == CNTW'(WIDTH - 1));
  assign finish  = div0_go || last;

  // MUL keeps the multiplier in acc[lo]; DIVU keeps quotient bits there
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    mul_nx   = acc[0] ? {mul_sum, acc[WIDTH-1:1]}
                      : {1'b0, acc[2*WIDTH-1:1]};
    div_sh   = acc[2*WIDTH-1:WIDTH-1];
    div_diff = div_sh - {1'b0, opnd_q};
    div_nx   = div_diff[WIDTH]
             ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
             : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    acc_nx   = (op_q == OP_MUL) ? mul_nx : div_nx;
  end

  always_comb begin
    fin_op   = op_q;
    fin_lo   = acc_nx[WIDTH-1:0];
    fin_hi   = acc_nx[2*WIDTH-1:WIDTH];
    fin_div0 = 1'b0;
    if (div0_go) begin
      fin_op   = OP_DIVU;
      fin_lo   = '1;
      fin_hi   = a;
      fin_div0 = 1'b1;
    end
  end

  mdu_flaggen #(
    .WIDTH (WIDTH)
  ) u_flaggen (
    .op     (fin_op),
    .res_lo (fin_lo),
    .res_hi (fin_hi),
    .div0   (fin_div0),
    .flags  (fin_flags)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nx = div0_go ? S_DONE : S_RUN;
        else       state_nx = S_IDLE;
      end
      S_RUN:   if (last) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == S_RUN);
    done   = (state == S_DONE);
    flag_w = done && fe_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q   <= OP_MUL;
      fe_q   <= 1'b0;
      opnd_q <= '0;
      acc    <= '0;
      cnt    <= '0;
      res_lo <= '0;
      res_hi <= '0;
      flags  <= '0;
    end else begin
      if (accept) begin
        op_q   <= op_t'(op);
        fe_q   <= flag_en;
        opnd_q <= op ? b : a;
        acc    <= op ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
        cnt    <= '0;
      end else if (state == S_RUN) begin
        acc <= acc_nx;
        cnt <= cnt + CNTW'(1);
      end
      if (finish) begin
        res_lo <= fin_lo;
        res_hi <= fin_hi;
        flags  <= fin_flags;
      end
    end
  end

endmodule

// File: tb/tb_seq_muldiv.sv
// Bench for seq_muldiv: directed vector table, handshake corner cases,
// and random operations against an arithmetic reference model.
module tb_seq_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic        flag_en;
  logic [15:0] a, b;
  logic        busy, done, flag_w;
  logic [15:0] res_lo, res_hi;
  logic [3:0]  flags;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_muldiv dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .flag_en (flag_en),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .res_lo  (res_lo),
    .res_hi  (res_hi),
    .flags   (flags),
    .flag_w  (flag_w)
  );

  typedef struct {
    logic        op;
    logic        fe;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] lo;
    logic [15:0] hi;
    logic [3:0]  fl;
    logic        fw;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 32-bit arithmetic and the flag rules
  task automatic model(input logic o, input logic [15:0] x,
                       input logic [15:0] y, output logic [15:0] lo,
                       output logic [15:0] hi, output logic [3:0] fl);
    logic [31:0] p;
    if (!o) begin
      p  = {16'h0, x} * {16'h0, y};
      lo = p[15:0];
      hi = p[31:16];
      fl = {hi != 0, lo == 0, lo[15], hi != 0};
    end else if (y == 0) begin
      lo = 16'hFFFF;
      hi = x;
      fl = {1'b1, 1'b0, 1'b1, 1'b0};
    end else begin
      lo = x / y;
      hi = x % y;
      fl = {1'b0, lo == 0, lo[15], 1'b0};
    end
  endtask

  // Issue one op, wait for done; lat = edges after the capturing edge
  task automatic run_op(input logic o, input logic fe,
                        input logic [15:0] x, input logic [15:0] y,
                        output int lat);
    @(negedge clk);
    op = o; flag_en = fe; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int exp_lat;
    logic [15:0] elo, ehi;
    logic [3:0]  efl;
    logic        saw;

    tbl[0] = '{1'b0, 1'b1, 16'd300, 16'd300, 16'h5F90, 16'h0001, 4'b1001, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 16'h00FF, 16'h0002, 16'h01FE, 16'h0000, 4'b0000, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 16'd1000, 16'd7, 16'h008E, 16'h0006, 4'b0000, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 16'd5, 16'd9, 16'h0000, 16'h0005, 4'b0100, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 4'b1010, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b1001, 1'b1};

    reset = 1'b0; start = 1'b0; op = 1'b0; flag_en = 1'b0;
    a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_flag_w", flag_w, 0);
    chk("reset_res", {res_hi, res_lo}, 0);
    chk("reset_flags", flags, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      exp_lat = (tbl[i].op && tbl[i].b == 0) ? 0 : 16;
      run_op(tbl[i].op, tbl[i].fe, tbl[i].a, tbl[i].b, lat);
      chk($sformatf("vec%0d_latency", i), lat, exp_lat);
      chk($sformatf("vec%0d_done", i), done, 1);
      chk($sformatf("vec%0d_res_lo", i), res_lo, tbl[i].lo);
      chk($sformatf("vec%0d_res_hi", i), res_hi, tbl[i].hi);
      chk($sformatf("vec%0d_flags", i), flags, tbl[i].fl);
      chk($sformatf("vec%0d_flag_w", i), flag_w, tbl[i].fw);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_done_pulse", i), {busy, done, flag_w}, 0);
      chk($sformatf("vec%0d_hold", i), res_lo, tbl[i].lo);
    end

    // Start during RUN ignored; start held in DONE chains directly
    @(negedge clk);
    op = 1'b0; flag_en = 1'b1; a = 16'h8000; b = 16'h0001; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy_e0", busy, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; op = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy_e5", busy, 1);
    lat = 5;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("b2b_first_latency", lat, 16);
    chk("b2b_first_lo", res_lo, 16'h8000);
    chk("b2b_first_hi", res_hi, 16'h0000);
    chk("b2b_first_flags", flags, 4'b0010);
    op = 1'b0; a = 16'd3; b = 16'd4; flag_en = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_no_idle", {busy, done}, 2'b10);
    chk("b2b_hold_during_run", res_lo, 16'h8000);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("b2b_second_latency", lat, 16);
    chk("b2b_second_lo", res_lo, 16'd12);
    chk("b2b_second_flag_w", flag_w, 0);

    // Reset in the middle of a multiply
    @(negedge clk);
    op = 1'b0; flag_en = 1'b1; a = 16'h1111; b = 16'h2222; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_ctrl", {busy, done, flag_w}, 0);
    chk("abort_res", {res_hi, res_lo}, 0);
    chk("abort_flags", flags, 0);
    @(negedge clk);
    reset = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done || flag_w || busy) saw = 1'b1;
    end
    chk("abort_no_done", saw, 0);
    run_op(1'b0, 1'b1, 16'd1234, 16'd56, lat);
    chk("abort_next_latency", lat, 16);
    chk("abort_next_lo", res_lo, 16'h0000 + 16'(1234 * 56));
    chk("abort_next_hi", res_hi, 16'h0001);

    // Random operations, about one in eight divides by zero
    for (int i = 0; i < 40; i++) begin
      logic        o;
      logic        fe;
      logic [15:0] x, y;
      o  = 1'($urandom_range(0, 1));
      fe = 1'($urandom_range(0, 1));
      x  = 16'($urandom);
      y  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) y = 16'($urandom_range(1, 15));
      model(o, x, y, elo, ehi, efl);
      exp_lat = (o && y == 0) ? 0 : 16;
      run_op(o, fe, x, y, lat);
      chk($sformatf("rnd%0d_latency", i), lat, exp_lat);
      chk($sformatf("rnd%0d_res", i), {res_hi, res_lo}, {ehi, elo});
      chk($sformatf("rnd%0d_flags", i), flags, efl);
      chk($sformatf("rnd%0d_flag_w", i), flag_w, fe);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_muldiv.md
Name: seq_muldiv

Overview:
- Multi-cycle 16-bit unsigned multiply/divide unit. It is the flag *producer* for the processor's condition logic.
- Result bits go onto the register write-back path. Flags go out as {CF,ZF,SF,OF}, the same ordering the condition logic consumes.
- A flag-write pulse is issued only when the operation completes.
- Start/busy/done handshake with the control unit; the main ALU stays single cycle.

Parameters:
- WIDTH, 16, operand and result width.
- CNTW, 5, iteration counter width; must satisfy 2^CNTW > WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; sampled on rising clk edge.
- op  in  1  0 = MUL (unsigned), 1 = DIVU (unsigned).
- flag_en  in  1  the issuing instruction wants flags written; captured with start.
- a  in  WIDTH  multiplicand / dividend; captured with start.
- b  in  WIDTH  multiplier / divisor; captured with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- res_lo  out  WIDTH  MUL: product[15:0]; DIVU: quotient.
- res_hi  out  WIDTH  MUL: product[31:16]; DIVU: remainder.
- flags  out  4  {CF,ZF,SF,OF} of the completed operation.
- flag_w  out  1  equals done & captured flag_en.

Behaviour:
- Reset (reset=0, async): state=IDLE; busy=0, done=0, flag_w=0; res_lo=0, res_hi=0, flags=4'b0000; counter=0.
- States:
  - IDLE: start=1 captures op, flag_en, a, b and goes to RUN. Exception: op=DIVU with b=0 goes straight to DONE.
  - RUN: one iteration per edge. After WIDTH iterations, registers outputs and goes to DONE.
  - DONE: done=1 for exactly one cycle. start=1 here is accepted as in IDLE (back-to-back). Otherwise go to IDLE.
- busy=1 exactly while state=RUN. start and inputs are ignored in RUN.
- Latency: start sampled at edge E0 gives iterations at E1..E16 and done=1 in the cycle after E16. Results are valid from that cycle.
- Divide-by-zero: done=1 in the cycle after E0. res_lo=16'hFFFF, res_hi=a.
- MUL algorithm:
  - Shift-add over a 2*WIDTH accumulator, multiplier LSB first.
  - Carry out of the upper-half add must be kept (WIDTH+1-bit adder).
- DIVU algorithm: restoring division with a WIDTH+1-bit partial remainder.
- Flags at completion:
  - ZF = (res_lo==0).
  - SF = res_lo[15].
  - MUL: CF = OF = (res_hi!=0), i.e. the product did not fit in 16 bits.
  - DIVU: CF = (b==0); OF = 0.
- Output hold: res_lo, res_hi and flags hold their values until the next completion or reset. They are not cleared by a new start.
- Reset mid-operation aborts immediately. No done/flag_w is issued for the aborted operation.

Decomposition:
- Package mdu_pkg:
  - op_t enum {OP_MUL, OP_DIVU}.
  - state_t enum {S_IDLE, S_RUN, S_DONE}.
  - Flag index constants FLAG_C=3, FLAG_Z=2, FLAG_S=1, FLAG_O=0, shared with the condition logic.
- One combinational sub-module, mdu_flaggen: inputs (op, res_lo, res_hi, div0), output flags.

Test Plan:
- MUL a=300, b=300 -> done after 17 edges: res_hi=0x0001, res_lo=0x5F90, flags=4'b1001, flag_w=1 (flag_en=1).
- MUL a=0x00FF, b=0x0002, flag_en=0 -> res_hi=0x0000, res_lo=0x01FE, flags=4'b0000, flag_w=0 while done=1.
- DIVU a=1000, b=7 -> res_lo=0x008E, res_hi=0x0006, flags=4'b0000. Then DIVU a=5, b=9 -> res_lo=0, res_hi=5, flags=4'b0100.
- DIVU a=0x1234, b=0 -> done in the cycle after E0: res_lo=0xFFFF, res_hi=0x1234, flags=4'b1010.
- MUL 0x8000*0x0001 with a second start pulsed at E5 (ignored while busy), and a new start held during DONE -> first result res_lo=0x8000, flags=4'b0010; second operation begins without an IDLE cycle.
- Assert reset at E8 of a MUL -> busy/done/flag_w=0 and outputs=0 immediately. No done pulse afterwards, and the next start completes normally.
